// File: rtl/alu_result_misr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_result_misr
//
// Response compactor for the ALU. It receives a stream of (alu_op, alu_c)
// result pairs and folds each one into a multiple-input signature register.
// It also counts accepted samples, records which opcodes were seen, and
// compares the final signature against GOLDEN. This lets the ALU be checked
// on silicon/FPGA without inspecting waveforms.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   start       begin a run (honoured in IDLE or DONE only)
//   in_valid    alu_op/alu_c carry a valid result
//   in_ready    block accepts a result this cycle (high in COLLECT)
//   alu_op      opcode that produced alu_c
//   alu_c       ALU result C
//   busy        run in progress (COLLECT)
//   done        run complete, outputs frozen
//   pass        done and signature == GOLDEN
//   signature   current MISR value
//   sample_cnt  transfers accepted this run
//   op_seen     bit k set once opcode k has been accepted this run
// ---------------------------------------------------------------------------
module alu_result_misr #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_SAMPLES = 13,
    parameter logic [WIDTH-1:0] POLY        = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED        = 32'hFFFFFFFF,
    parameter logic [WIDTH-1:0] GOLDEN      = 32'h00000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       sample_cnt,
    output logic [15:0]      op_seen
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_nx;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_nx;
    logic [15:0]      seen_q;
    logic [15:0]      seen_nx;
    logic [WIDTH-1:0] folded;

    // One MISR step: shift left, apply the feedback polynomial when the
    // outgoing bit is set, then XOR in the sample with the opcode placed in
    // the top nibble so that the same C from different opcodes compacts
    // differently.
    always_comb begin
        folded = {sig_q[WIDTH-2:0], 1'b0}
               ^ (sig_q[WIDTH-1] ? POLY : '0)
               ^ alu_c
               ^ {alu_op, {(WIDTH-4){1'b0}}};
    end

    // Next-state and next-data logic. A transfer is simply in_valid while in
    // COLLECT, since in_ready is decoded from that state alone. The transfer
    // that brings the count to NUM_SAMPLES moves straight to DONE so the
    // final signature is visible right after that edge.
    always_comb begin
        state_nx = state;
        sig_nx   = sig_q;
        cnt_nx   = cnt_q;
        seen_nx  = seen_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_COLLECT;
                    sig_nx   = SEED;
                    cnt_nx   = '0;
                    seen_nx  = '0;
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    sig_nx          = folded;
                    cnt_nx          = cnt_q + 8'd1;
                    seen_nx[alu_op] = 1'b1;
                    if (cnt_q + 8'd1 == LAST_CNT) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything to zero
    // (signature included) so an aborted run leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sig_q  <= '0;
            cnt_q  <= '0;
            seen_q <= '0;
        end else begin
            state  <= state_nx;
            sig_q  <= sig_nx;
            cnt_q  <= cnt_nx;
            seen_q <= seen_nx;
        end
    end

    // Outputs come only from the state and data registers, so there is no
    // combinational path from start or in_valid to any output.
    always_comb begin
        in_ready   = (state == ST_COLLECT);
        busy       = (state == ST_COLLECT);
        done       = (state == ST_DONE);
        pass       = (state == ST_DONE) && (sig_q == GOLDEN);
        signature  = sig_q;
        sample_cnt = cnt_q;
        op_seen    = seen_q;
    end

endmodule

// File: doc/alu_result_misr.md
# alu_result_misr

Hardware response compactor for the ALU: it consumes a stream of (ALUOp, C) result pairs and folds them into a multiple-input signature register (MISR). It also counts samples, records which opcodes were seen, and compares the final signature against a golden value. It is the receiving end of the ALU stimulus sequence (opcodes 0..12 applied to a fixed A/B pair). This lets the ALU be checked on silicon/FPGA without a simulator-side waveform inspection.

## Interface
Parameters:
- WIDTH, 32, datapath width of C and of the signature
- NUM_SAMPLES, 13, transfers per run (1..255)
- POLY, 32'h04C11DB7, MISR feedback polynomial (low WIDTH bits used)
- SEED, 32'hFFFFFFFF, signature value loaded on start
- GOLDEN, 32'h00000000, expected final signature

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE or DONE only)
- in_valid  in  1  alu_op/alu_c hold a valid result
- in_ready  out  1  block accepts a result this cycle
- alu_op  in  4  opcode that produced alu_c
- alu_c  in  WIDTH  ALU result C
- busy  out  1  run in progress (COLLECT)
- done  out  1  run complete, outputs frozen
- pass  out  1  done && signature == GOLDEN
- signature  out  WIDTH  current MISR value
- sample_cnt  out  8  transfers accepted this run
- op_seen  out  16  bit k set once opcode k accepted this run

## Operation
- FSM states: IDLE, COLLECT, DONE. Encoding is free.
- IDLE: in_ready=0, busy=0, done=0. start=1 → load signature=SEED, sample_cnt=0, op_seen=0, go COLLECT.
- COLLECT: in_ready=1, busy=1. start is ignored. A transfer occurs on a cycle with in_valid && in_ready.
- On each transfer:
  - d = alu_c ^ (alu_op << (WIDTH-4)), i.e. the opcode is XORed into the top 4 bits.
  - signature ← {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ d.
  - sample_cnt ← sample_cnt+1.
  - op_seen[alu_op] ← 1.
- The transfer that makes sample_cnt == NUM_SAMPLES → DONE. No further transfers are accepted.
- DONE: in_ready=0, busy=0, done=1, pass=(signature==GOLDEN). signature/sample_cnt/op_seen hold. start=1 → same reload as IDLE, go COLLECT.
- in_valid with in_ready=0 is ignored. Nothing is sampled and no error is raised.
- Opcodes 13..15 are accepted and folded like any other.
- Arithmetic is modulo 2^WIDTH bitwise XOR only. sample_cnt never exceeds NUM_SAMPLES.

## Timing
- Reset (rst_n=0, async): state=IDLE, in_ready=0, busy=0, done=0, pass=0, signature=0, sample_cnt=0, op_seen=0. Effect is immediate, independent of clk.
- Reset mid-COLLECT aborts the run. No partial state survives. Deassertion is taken on a clean edge, and the first start is honoured on the first rising edge after rst_n=1.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid/start to any output.
- start high at edge n → busy/in_ready high after edge n. The first transfer is possible at edge n+1.
- One transfer per cycle max. Back-to-back transfers are legal every cycle.
- Final transfer at edge m → from edge m: in_ready=0, done=1, pass valid, signature final. Latency is 0 cycles beyond the transfer edge.
- Run length with in_valid tied high: NUM_SAMPLES+1 cycles from start to done.
- start held high in DONE restarts every time DONE is reached. A start asserted on the same edge as the final transfer is ignored because the block is still in COLLECT.

## Test plan
- Reset/idle: apply rst_n=0 mid-cycle. All outputs drop to 0 immediately, with no clock needed. Drive in_valid=1 in IDLE for 5 cycles → sample_cnt stays 0 and signature stays 0.
- Single sample, SEED=0, NUM_SAMPLES=1: start, then op=0, C=32'h00000005 → done=1 next edge, signature=32'h00000005, op_seen=16'h0001. Repeat with op=1, C=0 → signature=32'h10000000, op_seen=16'h0002.
- Shift/feedback, default SEED=32'hFFFFFFFF, NUM_SAMPLES=1: op=0, C=0 → signature=32'hFB3EE249. SEED=0, NUM_SAMPLES=2, (op0,C=1) then (op0,C=0) → 32'h00000002.
- Handshake gaps: NUM_SAMPLES=13, stream ops 0..12 with in_valid toggled randomly → sample_cnt=13, op_seen=16'h1FFF. Signature equals the gap-free run. in_ready is low the cycle after the 13th transfer.
- Pass/fail: set GOLDEN to the signature from the previous run and rerun → pass=1. Flip one bit of C on op 7 → pass=0, done=1.
- Abort and restart: pull rst_n low after 6 transfers → all outputs 0. Then start a full run → result is identical to an uninterrupted run. Start in DONE → reload SEED, busy=1 next edge.
